vga_update_arbiter: RTL and testbench

- Shares the VGA text-memory write port (Port_ID 40 = address latch, Port_ID 41 = data write) between two internal requesters.
- Requesters are the PicoBlaze shadow-update path and the hardware clock/timer digit updater.
- Issues each granted update as a two-cycle port-write sequence toward the VGA central block.
- When configured, defers writes to the vertical-sync window so the pointer memory never changes mid-frame.

---
 rtl/vga_update_arbiter_if.sv | 26 ++
 rtl/vga_update_arbiter.sv | 138 +++++++++++++
 tb/tb_vga_update_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_update_arbiter_if.sv
// Requester and VGA-port signal bundle for vga_update_arbiter.
// The arbiter uses the master view. Requesters and the VGA central block use the slave view.
interface vga_update_arbiter_if;
   logic       req0;
   logic [3:0] addr0;
   logic [7:0] data0;
   logic       ack0;
   logic       req1;
   logic [3:0] addr1;
   logic [7:0] data1;
   logic       ack1;
   logic [7:0] Port_ID;
   logic [7:0] Port_Data;
   logic       Write_Strobe;
   logic       busy;

   modport master (
      input  req0, addr0, data0, req1, addr1, data1,
      output ack0, ack1, Port_ID, Port_Data, Write_Strobe, busy
   );

   modport slave (
      output req0, addr0, data0, req1, addr1, data1,
      input  ack0, ack1, Port_ID, Port_Data, Write_Strobe, busy
   );
endinterface

// File: rtl/vga_update_arbiter.sv
// Round-robin arbiter sharing the VGA text-memory port write path between two requesters.
// Each grant becomes an address-latch write followed by a data write, optionally gated to VSync.
//
//   state  | meaning
//   IDLE   | no grant held; arbitrate among pending requests
//   WAIT   | grant captured; wait for the write window to open
//   ADDR   | address-latch port write on the bus
//   DATA   | data port write on the bus, ack to the granted requester
//   GAP    | bus quiet for one cycle before the next arbitration
module vga_update_arbiter #(
   parameter logic [7:0]  PORT_ADDR     = 8'd40,
   parameter logic [7:0]  PORT_DATA     = 8'd41,
   parameter bit          SYNC_BLANK    = 1'b1,
   parameter int unsigned MAX_PER_FRAME = 8
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   VSync,
   vga_update_arbiter_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_ADDR = 3'd2,
      S_DATA = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   localparam logic [3:0] MAX_CNT = MAX_PER_FRAME[3:0];

   state_t     state_q;
   logic [7:0] port_id_q;
   logic [7:0] port_data_q;
   logic       strobe_q;
   logic       ack0_q;
   logic       ack1_q;
   logic       busy_q;
   logic       rr_last_q;
   logic       gnt_q;
   logic [3:0] addr_q;
   logic [7:0] data_q;
   logic [3:0] frame_cnt_q;
   logic       vsync_q;

   logic       grant1;
   logic       window_ok;
   logic       vsync_rise;

   // With both requesting, the one that was not granted last wins.
   assign grant1     = bus.req1 && (!bus.req0 || !rr_last_q);
   assign vsync_rise = !vsync_q && VSync;
   assign window_ok  = !SYNC_BLANK || (!VSync && (frame_cnt_q < MAX_CNT));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         port_id_q   <= 8'h00;
         port_data_q <= 8'h00;
         strobe_q    <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
         rr_last_q   <= 1'b1;
         gnt_q       <= 1'b0;
         addr_q      <= 4'h0;
         data_q      <= 8'h00;
      end else begin
         port_id_q   <= 8'h00;
         port_data_q <= 8'h00;
         strobe_q    <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req0 || bus.req1) begin
                  gnt_q     <= grant1;
                  rr_last_q <= grant1;
                  addr_q    <= grant1 ? bus.addr1 : bus.addr0;
                  data_q    <= grant1 ? bus.data1 : bus.data0;
                  busy_q    <= 1'b1;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (window_ok) begin
                  port_id_q   <= PORT_ADDR;
                  port_data_q <= {4'h0, addr_q};
                  strobe_q    <= 1'b1;
                  state_q     <= S_ADDR;
               end
            end
            S_ADDR: begin
               // Committed once the address is latched; a closing window does not split the pair.
               port_id_q   <= PORT_DATA;
               port_data_q <= data_q;
               strobe_q    <= 1'b1;
               ack0_q      <= !gnt_q;
               ack1_q      <= gnt_q;
               state_q     <= S_DATA;
            end
            S_DATA: begin
               state_q <= S_GAP;
            end
            S_GAP: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         frame_cnt_q <= 4'h0;
         vsync_q     <= 1'b1;
      end else begin
         vsync_q <= VSync;
         if (vsync_rise) begin
            frame_cnt_q <= 4'h0;
         end else if (SYNC_BLANK && (state_q == S_DATA) && (frame_cnt_q < MAX_CNT)) begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
         end
      end
   end

   assign bus.Port_ID      = port_id_q;
   assign bus.Port_Data    = port_data_q;
   assign bus.Write_Strobe = strobe_q;
   assign bus.ack0         = ack0_q;
   assign bus.ack1         = ack1_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vga_update_arbiter.sv
// Directed bench for vga_update_arbiter: one free-running instance and one VSync-gated
// instance with a two-write frame budget.
module tb_vga_update_arbiter;

   logic CLK;
   logic RESET;
   logic vsync_a;
   logic vsync_b;

   vga_update_arbiter_if bus_a ();
   vga_update_arbiter_if bus_b ();

   vga_update_arbiter #(.SYNC_BLANK(1'b0), .MAX_PER_FRAME(8)) dut_a (
      .CLK(CLK), .RESET(RESET), .VSync(vsync_a), .bus(bus_a)
   );

   vga_update_arbiter #(.SYNC_BLANK(1'b1), .MAX_PER_FRAME(2)) dut_b (
      .CLK(CLK), .RESET(RESET), .VSync(vsync_b), .bus(bus_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       r0;
      logic [3:0] a0;
      logic [7:0] d0;
      logic       r1;
      logic [3:0] a1;
      logic [7:0] d1;
      logic       early_drop;
      logic       exp_sel;
      logic [3:0] exp_addr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] wr_data [2];
      int         nw;
      bit         found;
      bit         saw_strobe;
      bit         reraised;
      bit         e0, e1;

      vecs[0] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hA, 8'h5A, 1'b0, 1'b1, 4'hA, 8'h5A};
      vecs[1] = '{1'b1, 4'h0, 8'hFF, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'hFF};
      vecs[2] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'h00, 1'b0, 1'b1, 4'hF, 8'h00};
      vecs[3] = '{1'b1, 4'h3, 8'h81, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h3, 8'h81};
      vecs[4] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 8'hC3, 1'b1, 1'b1, 4'h7, 8'hC3};

      RESET   = 1'b0;
      vsync_a = 1'b1;
      vsync_b = 1'b1;
      bus_a.req0 = 1'b1; bus_a.addr0 = 4'h5; bus_a.data0 = 8'h3C;
      bus_a.req1 = 1'b0; bus_a.addr1 = 4'h0; bus_a.data1 = 8'h00;
      bus_b.req0 = 1'b0; bus_b.addr0 = 4'h0; bus_b.data0 = 8'h00;
      bus_b.req1 = 1'b0; bus_b.addr1 = 4'h0; bus_b.data1 = 8'h00;

      // Reset held with a pending request
      tick(); tick(); tick();
      chk("rst_strobe", bus_a.Write_Strobe, 1'b0);
      chk("rst_port_id", bus_a.Port_ID, 8'h00);
      chk("rst_port_data", bus_a.Port_Data, 8'h00);
      chk("rst_ack0", bus_a.ack0, 1'b0);
      chk("rst_busy", bus_a.busy, 1'b0);
      chk("rst_b_busy", bus_b.busy, 1'b0);

      // Release: grant, ADDR, DATA on the following three edges
      RESET = 1'b1;
      tick();
      chk("first_wait_busy", bus_a.busy, 1'b1);
      chk("first_wait_strobe", bus_a.Write_Strobe, 1'b0);
      tick();
      chk("first_addr_id", bus_a.Port_ID, 8'd40);
      chk("first_addr_data", bus_a.Port_Data, 8'h05);
      chk("first_addr_strobe", bus_a.Write_Strobe, 1'b1);
      chk("first_addr_ack0", bus_a.ack0, 1'b0);
      tick();
      chk("first_data_id", bus_a.Port_ID, 8'd41);
      chk("first_data_data", bus_a.Port_Data, 8'h3C);
      chk("first_data_strobe", bus_a.Write_Strobe, 1'b1);
      chk("first_data_ack0", bus_a.ack0, 1'b1);
      bus_a.req0 = 1'b0;
      tick();
      chk("first_gap_strobe", bus_a.Write_Strobe, 1'b0);
      chk("first_gap_id", bus_a.Port_ID, 8'h00);
      chk("first_gap_ack0", bus_a.ack0, 1'b0);
      tick();
      chk("first_idle_busy", bus_a.busy, 1'b0);

      // Single-requester vectors on the free-running instance
      for (int i = 0; i < 5; i++) begin
         bus_a.req0 = vecs[i].r0; bus_a.addr0 = vecs[i].a0; bus_a.data0 = vecs[i].d0;
         bus_a.req1 = vecs[i].r1; bus_a.addr1 = vecs[i].a1; bus_a.data1 = vecs[i].d1;
         tick();
         chk($sformatf("v%0d_wait_busy", i), bus_a.busy, 1'b1);
         chk($sformatf("v%0d_wait_strobe", i), bus_a.Write_Strobe, 1'b0);
         if (vecs[i].early_drop) begin
            bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
            bus_a.addr0 = ~vecs[i].a0; bus_a.data0 = ~vecs[i].d0;
            bus_a.addr1 = ~vecs[i].a1; bus_a.data1 = ~vecs[i].d1;
         end
         tick();
         chk($sformatf("v%0d_addr_id", i), bus_a.Port_ID, 8'd40);
         chk($sformatf("v%0d_addr_data", i), bus_a.Port_Data, {4'h0, vecs[i].exp_addr});
         chk($sformatf("v%0d_addr_strobe", i), bus_a.Write_Strobe, 1'b1);
         tick();
         chk($sformatf("v%0d_data_id", i), bus_a.Port_ID, 8'd41);
         chk($sformatf("v%0d_data_data", i), bus_a.Port_Data, vecs[i].exp_data);
         chk($sformatf("v%0d_ack0", i), bus_a.ack0, !vecs[i].exp_sel);
         chk($sformatf("v%0d_ack1", i), bus_a.ack1, vecs[i].exp_sel);
         bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
         tick();
         chk($sformatf("v%0d_gap_strobe", i), bus_a.Write_Strobe, 1'b0);
         chk($sformatf("v%0d_gap_data", i), bus_a.Port_Data, 8'h00);
         tick();
         chk($sformatf("v%0d_idle_busy", i), bus_a.busy, 1'b0);
      end

      // Contention: last grant was requester 1, so requester 0 leads
      bus_a.req0 = 1'b1; bus_a.addr0 = 4'h1; bus_a.data0 = 8'h11;
      bus_a.req1 = 1'b1; bus_a.addr1 = 4'h2; bus_a.data1 = 8'h22;
      for (int c = 1; c <= 24; c++) begin
         tick();
         e0 = ((c % 5) == 3) && (((c / 5) % 2) == 0);
         e1 = ((c % 5) == 3) && (((c / 5) % 2) == 1);
         chk($sformatf("rr_c%0d_ack0", c), bus_a.ack0, e0);
         chk($sformatf("rr_c%0d_ack1", c), bus_a.ack1, e1);
         if (e0 || e1)
            chk($sformatf("rr_c%0d_data", c), bus_a.Port_Data, e0 ? 8'h11 : 8'h22);
         if (c == 18) bus_a.req1 = 1'b0;
         if (c == 23) bus_a.req0 = 1'b0;
      end
      tick();
      chk("rr_end_busy", bus_a.busy, 1'b0);

      // Sync gating: request held while VSync is high
      bus_b.req1 = 1'b1; bus_b.addr1 = 4'h9; bus_b.data1 = 8'h99;
      saw_strobe = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus_b.Write_Strobe) saw_strobe = 1'b1;
      end
      chk("gate_busy", bus_b.busy, 1'b1);
      chk("gate_no_strobe", saw_strobe, 1'b0);
      vsync_b = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 3 && !found; c++) begin
         tick();
         if (bus_b.Write_Strobe) found = 1'b1;
      end
      chk("gate_addr_seen", found, 1'b1);
      chk("gate_addr_id", bus_b.Port_ID, 8'd40);
      chk("gate_addr_data", bus_b.Port_Data, 8'h09);
      tick();
      chk("gate_data_id", bus_b.Port_ID, 8'd41);
      chk("gate_data_data", bus_b.Port_Data, 8'h99);
      chk("gate_ack1", bus_b.ack1, 1'b1);
      bus_b.req1 = 1'b0;
      tick(); tick();

      // Frame budget of two: third update must wait for the next window
      vsync_b = 1'b1;
      tick(); tick();
      bus_b.req0 = 1'b1; bus_b.addr0 = 4'h1; bus_b.data0 = 8'hA1;
      bus_b.req1 = 1'b1; bus_b.addr1 = 4'h2; bus_b.data1 = 8'hB2;
      tick(); tick();
      vsync_b = 1'b0;
      nw = 0;
      reraised = 1'b0;
      wr_data[0] = 8'h00; wr_data[1] = 8'h00;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus_b.Write_Strobe && bus_b.Port_ID == 8'd41) begin
            if (nw < 2) wr_data[nw] = bus_b.Port_Data;
            nw++;
         end
         if (bus_b.ack0 && !reraised) begin
            bus_b.addr0 = 4'h3; bus_b.data0 = 8'hC3;
            reraised = 1'b1;
         end
         if (bus_b.ack1) bus_b.req1 = 1'b0;
      end
      chk("budget_writes", nw, 2);
      chk("budget_first", wr_data[0], 8'hA1);
      chk("budget_second", wr_data[1], 8'hB2);
      chk("budget_busy", bus_b.busy, 1'b1);
      vsync_b = 1'b1;
      saw_strobe = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus_b.Write_Strobe) saw_strobe = 1'b1;
      end
      chk("budget_hold_no_strobe", saw_strobe, 1'b0);
      vsync_b = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 5 && !found; c++) begin
         tick();
         if (bus_b.ack0) found = 1'b1;
      end
      chk("budget_third_ack0", found, 1'b1);
      chk("budget_third_data", bus_b.Port_Data, 8'hC3);
      bus_b.req0 = 1'b0;
      tick(); tick();

      // Mid-sequence reset between ADDR and DATA
      bus_a.req0 = 1'b1; bus_a.addr0 = 4'h4; bus_a.data0 = 8'h44;
      tick();
      tick();
      chk("abort_addr_strobe", bus_a.Write_Strobe, 1'b1);
      chk("abort_addr_id", bus_a.Port_ID, 8'd40);
      RESET = 1'b0;
      bus_a.req1 = 1'b1; bus_a.addr1 = 4'h6; bus_a.data1 = 8'h66;
      #1;
      chk("abort_strobe", bus_a.Write_Strobe, 1'b0);
      chk("abort_busy", bus_a.busy, 1'b0);
      saw_strobe = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus_a.Write_Strobe) saw_strobe = 1'b1;
         if (bus_a.ack0 || bus_a.ack1) found = 1'b1;
      end
      chk("abort_no_data_strobe", saw_strobe, 1'b0);
      chk("abort_no_ack", found, 1'b0);
      RESET = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 3) begin
            chk("post_abort_ack0", bus_a.ack0, 1'b1);
            chk("post_abort_data0", bus_a.Port_Data, 8'h44);
            bus_a.req0 = 1'b0;
         end
         if (c == 8) begin
            chk("post_abort_ack1", bus_a.ack1, 1'b1);
            chk("post_abort_data1", bus_a.Port_Data, 8'h66);
            bus_a.req1 = 1'b0;
         end
      end
      tick(); tick();
      chk("final_busy", bus_a.busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
